// File: rtl/key_load_ctrl.sv
// key_load_ctrl: receives a framed serial key (LSB first, then an even-parity
// bit), checks parity and commits the key atomically to key_out. After
// MAX_FAIL consecutive parity failures the block locks out until reset.
module key_load_ctrl #(
  parameter int unsigned KEY_W    = 32,
  parameter int unsigned MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_bit_in,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             load_done,
  output logic             load_err,
  output logic             locked_out,
  output logic [3:0]       fail_count
);

  localparam int unsigned CNT_W  = $clog2(KEY_W);
  localparam int unsigned FAIL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PAR,
    ST_CHECK,
    ST_LOCKOUT
  } state_e;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                kv_q, kv_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                lock_q, lock_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                accept;
  logic [FAIL_W-1:0]   fail_inc;

  assign accept = key_bit_valid && ready_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    key_d    = key_q;
    kv_d     = kv_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    lock_d   = lock_q;
    fail_d   = fail_q;
    fail_inc = fail_q + FAIL_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          sr_d  = {key_bit_in, sr_q[KEY_W-1:1]};
          acc_d = acc_q ^ key_bit_in;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_W - 1)) begin
            state_d = ST_PAR;
          end
        end
      end
      ST_PAR: begin
        if (accept) begin
          acc_d   = acc_q ^ key_bit_in;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!acc_q) begin
          key_d   = sr_q;
          kv_d    = 1'b1;
          done_d  = 1'b1;
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == FAIL_W'(MAX_FAIL)) begin
            // Drop the key together with the final error so no stale key survives lockout
            key_d   = '0;
            kv_d    = 1'b0;
            lock_d  = 1'b1;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCKOUT: begin
        key_d  = '0;
        kv_d   = 1'b0;
        lock_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_SHIFT) || (state_d == ST_PAR);
    busy_d  = (state_d == ST_SHIFT) || (state_d == ST_PAR) || (state_d == ST_CHECK);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      fail_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign key_bit_ready = ready_q;
  assign key_out       = key_q;
  assign key_valid     = kv_q;
  assign busy          = busy_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign locked_out    = lock_q;
  assign fail_count    = fail_q;

endmodule
